// File: rtl/imem_loader.sv
// imem_loader: frames a 9-bit valid/ready word stream into 60-word blocks written to imem, held until released
//   clock         posedge clock for all logic
//   reset         synchronous active-high reset
//   in_data       stream data word
//   in_valid      in_data valid
//   in_first      in_data is the first word of a frame
//   in_ready      loader accepts a word this cycle (not FULL)
//   iaddr/idata   imem write address/data, valid when wr=1
//   wr            imem write enable, one cycle after the transfer
//   loaded        a complete frame is resident in imem
//   release_frame consumer is done with the frame, honoured only while loaded=1
//   sync_err      one-cycle pulse when in_first arrives mid-frame
//   frame_cnt     completed frames modulo 256
module imem_loader #(
  parameter int DEPTH = 60,
  parameter int AW = 6,
  parameter int DW = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_first,
  output logic          in_ready,
  output logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  output logic          wr,
  output logic          loaded,
  input  logic          release_frame,
  output logic          sync_err,
  output logic [7:0]    frame_cnt
);
  typedef enum logic [1:0] {HUNT, FILL, FULL} state_t;
  state_t state, state_n;
  logic [AW-1:0] wptr, wptr_n, iaddr_n;
  logic [DW-1:0] idata_n;
  logic [7:0] cnt_n;
  logic wr_n, sync_n, loaded_n, xfer, last;
  assign in_ready = state != FULL;
  assign xfer = in_valid & in_ready;
  assign last = wptr == AW'(DEPTH - 1);
  always_comb begin
    state_n = state;
    wptr_n = wptr;
    cnt_n = frame_cnt;
    sync_n = 1'b0;
    wr_n = xfer & (in_first | state == FILL);
    iaddr_n = iaddr;
    idata_n = idata;
    // loaded trails the state by one cycle, so a release is only seen once the frame is visible
    loaded_n = state == FULL & ~(release_frame & loaded);
    if (wr_n) begin
      iaddr_n = in_first ? '0 : wptr;
      idata_n = in_data;
    end
    if (state == FULL) begin
      if (release_frame & loaded) state_n = HUNT;
    end else if (xfer & in_first) begin
      state_n = FILL;
      wptr_n = AW'(1);
      sync_n = state == FILL;
    end else if (xfer & state == FILL) begin
      state_n = last ? FULL : FILL;
      wptr_n = last ? '0 : wptr + AW'(1);
      cnt_n = frame_cnt + 8'(last);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HUNT;
      wptr <= '0;
      wr <= 1'b0;
      iaddr <= '0;
      idata <= '0;
      loaded <= 1'b0;
      sync_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      wptr <= wptr_n;
      wr <= wr_n;
      iaddr <= iaddr_n;
      idata <= idata_n;
      loaded <= loaded_n;
      sync_err <= sync_n;
      frame_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clock = 1'b0, reset = 1'b0, in_valid = 1'b0, in_first = 1'b0, release_frame = 1'b0;
  logic [8:0] in_data = '0;
  logic in_ready, wr, loaded, sync_err;
  logic [5:0] iaddr;
  logic [8:0] idata;
  logic [7:0] frame_cnt;
  int checks = 0, errors = 0;

  imem_loader dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_first(in_first),
    .in_ready(in_ready), .iaddr(iaddr), .idata(idata), .wr(wr), .loaded(loaded),
    .release_frame(release_frame), .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  task step();
    @(posedge clock);
    #1;
  endtask

  task do_reset();
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; release_frame = 1'b0; in_data = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task send_frame();
    int n;
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1; in_first = (i == 0); in_data = 9'(i);
      step();
    end
    in_valid = 1'b0; in_first = 1'b0;
    n = 0;
    while (!loaded && n < 5) begin step(); n++; end
    checks++;
    if (loaded !== 1'b1) begin errors++; $display("FAIL frame_loaded_timeout: loaded=%b required 1", loaded); end
    release_frame = 1'b1; step(); release_frame = 1'b0;
  endtask

  task test_reset();
    do_reset();
    checks++;
    if ({wr, iaddr, idata, loaded, sync_err, frame_cnt, in_ready} !== {1'b0, 6'd0, 9'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: wr=%b iaddr=%0d idata=%0d loaded=%b sync_err=%b frame_cnt=%0d in_ready=%b required 0 0 0 0 0 0 1",
               wr, iaddr, idata, loaded, sync_err, frame_cnt, in_ready);
    end
  endtask

  task test_full_frame();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1; in_first = (i == 0); in_data = 9'(i);
      step();
      checks++;
      if (wr !== 1'b1 || iaddr !== 6'(i) || idata !== 9'(i) || loaded !== 1'b0) begin
        errors++;
        $display("FAIL full_write[%0d]: wr=%b iaddr=%0d idata=%0d loaded=%b required 1 %0d %0d 0", i, wr, iaddr, idata, loaded, i, i);
      end
    end
    in_valid = 1'b0; in_first = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || frame_cnt !== 8'd1) begin
      errors++; $display("FAIL full_after_last: in_ready=%b frame_cnt=%0d required 0 1", in_ready, frame_cnt);
    end
    step();
    checks++;
    if (loaded !== 1'b1 || wr !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_loaded: loaded=%b wr=%b in_ready=%b required 1 0 0", loaded, wr, in_ready);
    end
    in_valid = 1'b1; in_data = 9'h1FF;
    step();
    in_valid = 1'b0;
    checks++;
    if (wr !== 1'b0 || loaded !== 1'b1) begin
      errors++; $display("FAIL full_ignores_valid: wr=%b loaded=%b required 0 1", wr, loaded);
    end
  endtask

  task test_hunt_discard();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_first = 1'b0; in_data = 9'(100 + i);
      step();
      checks++;
      if (wr !== 1'b0 || in_ready !== 1'b1 || loaded !== 1'b0) begin
        errors++; $display("FAIL hunt_discard[%0d]: wr=%b in_ready=%b loaded=%b required 0 1 0", i, wr, in_ready, loaded);
      end
    end
    in_valid = 1'b0;
  endtask

  task test_sync_err();
    int pulses;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_first = (i == 0); in_data = 9'(i);
      step();
    end
    in_first = 1'b1; in_data = 9'h1AA;
    step();
    checks++;
    if (sync_err !== 1'b1 || wr !== 1'b1 || iaddr !== 6'd0 || idata !== 9'h1AA) begin
      errors++; $display("FAIL sync_restart: sync_err=%b wr=%b iaddr=%0d idata=%h required 1 1 0 1aa", sync_err, wr, iaddr, idata);
    end
    pulses = 0;
    in_first = 1'b0;
    for (int k = 0; k < 59; k++) begin
      in_data = 9'(200 + k);
      step();
      if (sync_err) pulses++;
      checks++;
      if (wr !== 1'b1 || iaddr !== 6'(k + 1) || idata !== 9'(200 + k) || loaded !== 1'b0) begin
        errors++;
        $display("FAIL sync_refill[%0d]: wr=%b iaddr=%0d idata=%0d loaded=%b required 1 %0d %0d 0", k, wr, iaddr, idata, loaded, k + 1, 200 + k);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL sync_single_pulse: extra pulses=%0d required 0", pulses); end
    step();
    checks++;
    if (loaded !== 1'b1 || frame_cnt !== 8'd1) begin
      errors++; $display("FAIL sync_loaded: loaded=%b frame_cnt=%0d required 1 1", loaded, frame_cnt);
    end
  endtask

  task test_release();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1; in_first = (i == 0); in_data = 9'(59 - i); release_frame = 1'b1;
      step();
      checks++;
      if (wr !== 1'b1 || iaddr !== 6'(i) || idata !== 9'(59 - i)) begin
        errors++; $display("FAIL toggle_write[%0d]: wr=%b iaddr=%0d idata=%0d required 1 %0d %0d", i, wr, iaddr, idata, i, 59 - i);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (wr !== 1'b0) begin errors++; $display("FAIL toggle_idle[%0d]: wr=%b required 0", i, wr); end
    end
    release_frame = 1'b0;
    checks++;
    if (loaded !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL early_release_ignored: loaded=%b in_ready=%b required 1 0", loaded, in_ready);
    end
    step();
    checks++;
    if (loaded !== 1'b1) begin errors++; $display("FAIL loaded_hold: loaded=%b required 1", loaded); end
    release_frame = 1'b1;
    step();
    release_frame = 1'b0;
    checks++;
    if (loaded !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'd1) begin
      errors++; $display("FAIL release_honoured: loaded=%b in_ready=%b frame_cnt=%0d required 0 1 1", loaded, in_ready, frame_cnt);
    end
  endtask

  task test_mid_reset();
    do_reset();
    send_frame();
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_first = (i == 0); in_data = 9'(i);
      step();
    end
    reset = 1'b1; in_data = 9'h77;
    step();
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (wr !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'd0 || loaded !== 1'b0) begin
      errors++; $display("FAIL mid_reset: wr=%b in_ready=%b frame_cnt=%0d loaded=%b required 0 1 0 0", wr, in_ready, frame_cnt, loaded);
    end
    in_valid = 1'b1; in_first = 1'b0; in_data = 9'h11;
    step();
    checks++;
    if (wr !== 1'b0) begin errors++; $display("FAIL mid_reset_hunt: wr=%b required 0", wr); end
    in_first = 1'b1; in_data = 9'h55;
    step();
    in_first = 1'b0;
    in_data = 9'h66;
    checks++;
    if (wr !== 1'b1 || iaddr !== 6'd0 || idata !== 9'h55) begin
      errors++; $display("FAIL mid_reset_restart: wr=%b iaddr=%0d idata=%h required 1 0 55", wr, iaddr, idata);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (wr !== 1'b1 || iaddr !== 6'd1 || idata !== 9'h66) begin
      errors++; $display("FAIL mid_reset_second: wr=%b iaddr=%0d idata=%h required 1 1 66", wr, iaddr, idata);
    end
  endtask

  task test_frame_wrap();
    do_reset();
    for (int f = 0; f < 255; f++) send_frame();
    checks++;
    if (frame_cnt !== 8'd255) begin errors++; $display("FAIL frame_cnt_255: frame_cnt=%0d required 255", frame_cnt); end
    send_frame();
    checks++;
    if (frame_cnt !== 8'd0) begin errors++; $display("FAIL frame_cnt_wrap: frame_cnt=%0d required 0", frame_cnt); end
    send_frame();
    checks++;
    if (frame_cnt !== 8'd1) begin errors++; $display("FAIL frame_cnt_257: frame_cnt=%0d required 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_hunt_discard();
    test_sync_err();
    test_release();
    test_mid_reset();
    test_frame_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
